decode_stage: RTL

RV32I decode stage sitting directly downstream of fetch. It accepts {pc, insn} from fetch over a valid/ready handshake and buffers it in a 2-entry elastic (skid + output register). It splits the instruction into fields, generates the sign-extended immediate and flags illegal encodings. A registered, handshaked bundle is presented to the execute/register-read stage.

---
 rtl/rv32i_pkg.sv | 42 ++++
 rtl/decode_stage_imm_gen.sv | 43 ++++
 rtl/decode_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I decode definitions.
//   - Opcode constants (OPC_LOAD .. OPC_SYSTEM).
//   - Immediate format enum, imm_fmt_e.
//   - Decoded bundle struct, dec_bundle_t, held in the decode output register.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] insn;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } dec_bundle_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate generator.
// Ports:
//   insn_i     - raw 32-bit instruction
//   imm_fmt_o  - immediate format selected by the opcode (IMM_NONE if unknown)
//   imm_o      - sign-extended immediate, 0 for formats without one
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [XLEN-1:0] insn_i,
  output imm_fmt_e        imm_fmt_o,
  output logic [XLEN-1:0] imm_o
);

  logic [6:0] opcode;
  assign opcode = insn_i[6:0];

  always_comb begin
    imm_fmt_o = IMM_NONE;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_fmt_o = IMM_I;
      OPC_STORE:                      imm_fmt_o = IMM_S;
      OPC_BRANCH:                     imm_fmt_o = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_fmt_o = IMM_U;
      OPC_JAL:                        imm_fmt_o = IMM_J;
      default:                        imm_fmt_o = IMM_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (imm_fmt_o)
      IMM_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
      IMM_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      IMM_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                      insn_i[30:25], insn_i[11:8], 1'b0};
      IMM_U: imm_o = {insn_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                      insn_i[20], insn_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode stage behind fetch.
// A 2-entry elastic buffer (skid entry + output register) accepts {pc, insn}
// from fetch, decodes fields/immediate/illegal on the way into the output
// register, and presents the registered bundle downstream.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   f_valid_i / f_ready_o   - fetch handshake; f_ready_o is purely registered
//   f_pc_i, f_insn_i        - fetch payload
//   flush_i                 - drop every buffered entry and any same-cycle transfer
//   d_valid_o / d_ready_i   - downstream handshake
//   d_pc_o .. d_illegal_o   - registered decoded bundle
module decode_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid_i,
  output logic              f_ready_o,
  input  logic [AWIDTH-1:0] f_pc_i,
  input  logic [DWIDTH-1:0] f_insn_i,
  input  logic              flush_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [AWIDTH-1:0] d_pc_o,
  output logic [DWIDTH-1:0] d_insn_o,
  output logic [6:0]        d_opcode_o,
  output logic [4:0]        d_rd_o,
  output logic [4:0]        d_rs1_o,
  output logic [4:0]        d_rs2_o,
  output logic [2:0]        d_funct3_o,
  output logic [6:0]        d_funct7_o,
  output logic [DWIDTH-1:0] d_imm_o,
  output logic              d_illegal_o
);

  logic              skid_valid_q, skid_valid_d;
  logic [AWIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DWIDTH-1:0] skid_insn_q, skid_insn_d;
  logic              out_valid_q, out_valid_d;
  logic [AWIDTH-1:0] out_pc_q, out_pc_d;
  dec_bundle_t       out_q, out_d;

  logic              fire_in;
  logic              load;
  logic              have_src;
  logic [AWIDTH-1:0] src_pc;
  logic [DWIDTH-1:0] src_insn;
  imm_fmt_e          src_fmt;
  logic [DWIDTH-1:0] src_imm;
  logic              src_illegal;
  dec_bundle_t       src_dec;

  assign f_ready_o = !skid_valid_q;
  assign fire_in   = f_valid_i && f_ready_o;
  assign load      = !out_valid_q || d_ready_i;

  // While the skid is occupied f_ready_o is low, so the skid and a fetch
  // transfer never compete for the output register.
  assign have_src = skid_valid_q || fire_in;
  assign src_pc   = skid_valid_q ? skid_pc_q   : f_pc_i;
  assign src_insn = skid_valid_q ? skid_insn_q : f_insn_i;

  imm_gen u_imm_gen (
    .insn_i    (src_insn),
    .imm_fmt_o (src_fmt),
    .imm_o     (src_imm)
  );

  always_comb begin
    src_illegal = 1'b0;
    if (src_insn[1:0] != 2'b11) begin
      src_illegal = 1'b1;
    end else if (src_fmt == IMM_NONE) begin
      // Formats without an immediate: only OP, SYSTEM and FENCE are legal.
      case (src_insn[6:0])
        OPC_OP: begin
          if (src_insn[31:25] == 7'b0100000)
            src_illegal = !(src_insn[14:12] inside {3'b000, 3'b101});
          else
            src_illegal = (src_insn[31:25] != 7'b0000000);
        end
        OPC_SYSTEM, OPC_MISC_MEM: src_illegal = 1'b0;
        default:                  src_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    src_dec         = '0;
    src_dec.insn    = src_insn;
    src_dec.opcode  = src_insn[6:0];
    src_dec.rd      = src_insn[11:7];
    src_dec.rs1     = src_insn[19:15];
    src_dec.rs2     = src_insn[24:20];
    src_dec.funct3  = src_insn[14:12];
    src_dec.funct7  = src_insn[31:25];
    src_dec.imm     = src_illegal ? '0 : src_imm;
    src_dec.illegal = src_illegal;
  end

  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_insn_d  = skid_insn_q;
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_d        = out_q;
    if (flush_i) begin
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else if (load) begin
      out_valid_d  = have_src;
      skid_valid_d = 1'b0;
      // Data only moves with a real entry so outputs stay quiet when idle.
      if (have_src) begin
        out_pc_d = src_pc;
        out_d    = src_dec;
      end
    end else if (fire_in) begin
      skid_valid_d = 1'b1;
      skid_pc_d    = f_pc_i;
      skid_insn_d  = f_insn_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_insn_q  <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_q        <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_insn_q  <= skid_insn_d;
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_q        <= out_d;
    end
  end

  assign d_valid_o   = out_valid_q;
  assign d_pc_o      = out_pc_q;
  assign d_insn_o    = out_q.insn;
  assign d_opcode_o  = out_q.opcode;
  assign d_rd_o      = out_q.rd;
  assign d_rs1_o     = out_q.rs1;
  assign d_rs2_o     = out_q.rs2;
  assign d_funct3_o  = out_q.funct3;
  assign d_funct7_o  = out_q.funct7;
  assign d_imm_o     = out_q.imm;
  assign d_illegal_o = out_q.illegal;

endmodule
